// File: rtl/br_resolve.sv
// Branch resolution: FIFO of in-flight predictions, compared against EX outcomes to drive
// predictor updates and mispredict flushes. Optional counters under BR_RESOLVE_STATS_EN.
module br_resolve #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_Valid_i,
    input  logic [31:0] IF_PC_i,
    input  logic        IF_PredTaken_i,
    input  logic [31:0] IF_PredTarget_i,
    input  logic        Stall_i,
    input  logic        EX_Valid_i,
    input  logic [31:0] EX_PC_i,
    input  logic [31:0] EX_Target_i,
    input  logic        EX_IsBranch_i,
    input  logic        EX_Taken_i,
    output logic        Full_o,
    output logic        WriteEn_o,
    output logic        BranchTaken_o,
    output logic [31:0] WriteAddr_o,
    output logic [31:0] WriteTarget_o,
    output logic        Flush_o,
    output logic [31:0] RedirectPC_o,
    output logic        Err_o
`ifdef BR_RESOLVE_STATS_EN
    ,
    output logic [31:0] BranchCnt_o,
    output logic [31:0] MissCnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    entry_t      r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        r_write_en;
    logic        r_branch_taken;
    logic [31:0] r_write_addr;
    logic [31:0] r_write_target;
    logic        r_flush;
    logic [31:0] r_redirect_pc;
    logic        r_err;

    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    entry_t      w_head;
    logic        w_ex_req;
    logic        w_pop;
    logic        w_push;
    logic        w_mispredict;
    logic [31:0] w_redirect;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_count == (AW + 1)'(DEPTH));
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_ex_req = EX_Valid_i && !Stall_i;
    assign w_pop    = w_ex_req && !w_empty;
    assign w_push   = IF_Valid_i && !Stall_i && (!w_full || w_pop);

    always_comb begin
        w_mispredict = 1'b0;
        if (EX_IsBranch_i) begin
            if (w_head.pred_taken != EX_Taken_i)
                w_mispredict = 1'b1;
            else if (EX_Taken_i && (w_head.pred_target != EX_Target_i))
                w_mispredict = 1'b1;
        end else if (w_head.pred_taken) begin
            w_mispredict = 1'b1;
        end
        w_redirect = (EX_IsBranch_i && EX_Taken_i) ? EX_Target_i : EX_PC_i + 32'd4;
    end

    // Storage carries no reset; stale slots are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= '{pc: IF_PC_i, pred_taken: IF_PredTaken_i,
                                         pred_target: IF_PredTarget_i};
    end

    // A mispredict collapses the queue onto the post-pop read pointer, dropping any same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_pop && w_mispredict) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_wr_ptr <= r_rd_ptr + 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_en     <= 1'b0;
            r_branch_taken <= 1'b0;
            r_write_addr   <= '0;
            r_write_target <= '0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= '0;
            r_err          <= 1'b0;
        end else begin
            r_write_en <= w_pop && EX_IsBranch_i;
            r_flush    <= w_pop && w_mispredict;
            if (w_pop) begin
                r_branch_taken <= EX_Taken_i;
                r_write_addr   <= EX_PC_i;
                r_write_target <= EX_Target_i;
            end
            if (w_pop && w_mispredict)
                r_redirect_pc <= w_redirect;
            if (w_ex_req && (w_empty || (w_head.pc != EX_PC_i)))
                r_err <= 1'b1;
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (w_pop && EX_IsBranch_i && (r_branch_cnt != 32'hFFFF_FFFF))
                r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_pop && w_mispredict && (r_miss_cnt != 32'hFFFF_FFFF))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign BranchCnt_o = r_branch_cnt;
    assign MissCnt_o   = r_miss_cnt;
`endif

    assign Full_o        = w_full;
    assign WriteEn_o     = r_write_en;
    assign BranchTaken_o = r_branch_taken;
    assign WriteAddr_o   = r_write_addr;
    assign WriteTarget_o = r_write_target;
    assign Flush_o       = r_flush;
    assign RedirectPC_o  = r_redirect_pc;
    assign Err_o         = r_err;
endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: directed vector table, a queue-based reference model driven by
// random stimulus, and a counter sequence when BR_RESOLVE_STATS_EN is defined.
module tb_br_resolve;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        IF_Valid_i, IF_PredTaken_i, Stall_i, EX_Valid_i, EX_IsBranch_i, EX_Taken_i;
    logic [31:0] IF_PC_i, IF_PredTarget_i, EX_PC_i, EX_Target_i;
    logic        Full_o, WriteEn_o, BranchTaken_o, Flush_o, Err_o;
    logic [31:0] WriteAddr_o, WriteTarget_o, RedirectPC_o;
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] BranchCnt_o, MissCnt_o;
`endif

    br_resolve #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .IF_Valid_i(IF_Valid_i), .IF_PC_i(IF_PC_i), .IF_PredTaken_i(IF_PredTaken_i),
        .IF_PredTarget_i(IF_PredTarget_i), .Stall_i(Stall_i), .EX_Valid_i(EX_Valid_i),
        .EX_PC_i(EX_PC_i), .EX_Target_i(EX_Target_i), .EX_IsBranch_i(EX_IsBranch_i),
        .EX_Taken_i(EX_Taken_i), .Full_o(Full_o), .WriteEn_o(WriteEn_o),
        .BranchTaken_o(BranchTaken_o), .WriteAddr_o(WriteAddr_o),
        .WriteTarget_o(WriteTarget_o), .Flush_o(Flush_o), .RedirectPC_o(RedirectPC_o),
        .Err_o(Err_o)
`ifdef BR_RESOLVE_STATS_EN
        , .BranchCnt_o(BranchCnt_o), .MissCnt_o(MissCnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: in-flight predictions as a plain queue, outputs as last-known values.
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ment_t;
    ment_t       mq[$];
    logic        m_we, m_bt, m_fl, m_err;
    logic [31:0] m_wa, m_wt, m_rp, m_bcnt, m_mcnt;

    typedef struct {
        logic        r, ifv, ifpt, st, exv, exbr, extk;
        logic [31:0] ifpc, iftgt, expc, extgt;
        logic        we, bt, fl, fu, er;
        logic [31:0] wa, rp;
    } vec_t;
    vec_t vec[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, ifv, input logic [31:0] ifpc, input logic ifpt,
                          input logic [31:0] iftgt, input logic st, exv,
                          input logic [31:0] expc, extgt, input logic exbr, extk);
        rst = r; IF_Valid_i = ifv; IF_PC_i = ifpc; IF_PredTaken_i = ifpt;
        IF_PredTarget_i = iftgt; Stall_i = st; EX_Valid_i = exv; EX_PC_i = expc;
        EX_Target_i = extgt; EX_IsBranch_i = exbr; EX_Taken_i = extk;
    endtask

    // Advance the model by the rules applied to the current inputs, then clock the DUT.
    task automatic tick();
        bit    do_pop, do_push, miss, ex_req;
        ment_t h, e;
        if (rst) begin
            mq.delete();
            m_we = 0; m_bt = 0; m_fl = 0; m_err = 0;
            m_wa = 0; m_wt = 0; m_rp = 0; m_bcnt = 0; m_mcnt = 0;
        end else begin
            ex_req  = EX_Valid_i && !Stall_i;
            do_pop  = ex_req && (mq.size() > 0);
            do_push = IF_Valid_i && !Stall_i && ((mq.size() < DEPTH) || do_pop);
            miss    = 0;
            if (ex_req && (mq.size() == 0 || mq[0].pc != EX_PC_i)) m_err = 1;
            if (do_pop) begin
                h = mq[0];
                if (EX_IsBranch_i)
                    miss = (h.pt != EX_Taken_i) || (EX_Taken_i && h.tgt != EX_Target_i);
                else
                    miss = h.pt;
                m_bt = EX_Taken_i; m_wa = EX_PC_i; m_wt = EX_Target_i;
                if (miss) m_rp = (EX_IsBranch_i && EX_Taken_i) ? EX_Target_i : EX_PC_i + 4;
                if (EX_IsBranch_i && m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
                if (miss && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
                void'(mq.pop_front());
            end
            m_we = do_pop && EX_IsBranch_i;
            m_fl = do_pop && miss;
            if (do_push) begin
                e.pc = IF_PC_i; e.pt = IF_PredTaken_i; e.tgt = IF_PredTarget_i;
                mq.push_back(e);
            end
            if (miss) mq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model();
        chk("WriteEn_o", 32'(WriteEn_o), 32'(m_we));
        chk("Flush_o", 32'(Flush_o), 32'(m_fl));
        chk("BranchTaken_o", 32'(BranchTaken_o), 32'(m_bt));
        chk("WriteAddr_o", WriteAddr_o, m_wa);
        chk("WriteTarget_o", WriteTarget_o, m_wt);
        chk("RedirectPC_o", RedirectPC_o, m_rp);
        chk("Full_o", 32'(Full_o), 32'(mq.size() == DEPTH));
        chk("Err_o", 32'(Err_o), 32'(m_err));
`ifdef BR_RESOLVE_STATS_EN
        chk("BranchCnt_o", BranchCnt_o, m_bcnt);
        chk("MissCnt_o", MissCnt_o, m_mcnt);
`endif
    endtask

    function automatic vec_t mk(input logic r, ifv, input logic [31:0] ifpc, input logic ifpt,
                                input logic [31:0] iftgt, input logic st, exv,
                                input logic [31:0] expc, extgt, input logic exbr, extk,
                                input logic we, bt, input logic [31:0] wa, input logic fl,
                                input logic [31:0] rp, input logic fu, er);
        vec_t v;
        v.r = r; v.ifv = ifv; v.ifpc = ifpc; v.ifpt = ifpt; v.iftgt = iftgt; v.st = st;
        v.exv = exv; v.expc = expc; v.extgt = extgt; v.exbr = exbr; v.extk = extk;
        v.we = we; v.bt = bt; v.wa = wa; v.fl = fl; v.rp = rp; v.fu = fu; v.er = er;
        return v;
    endfunction

    initial begin
        // Columns: rst ifv ifpc ifpt iftgt stall exv expc extgt br tk | we bt wa fl rp full err
        vec[0]  = mk(1,0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        vec[1]  = mk(0,1,'h100,0,0,0,0,0,0,0,0,      0,0,0,0,0,0,0);
        vec[2]  = mk(0,0,0,0,0,0,1,'h100,'h500,1,0,  1,0,'h100,0,0,0,0);
        vec[3]  = mk(0,1,'h200,0,0,0,0,0,0,0,0,      0,0,'h100,0,0,0,0);
        vec[4]  = mk(0,1,'h204,0,0,0,1,'h200,'h340,1,1, 1,1,'h200,1,'h340,0,0);
        vec[5]  = mk(0,0,0,0,0,0,1,'h204,0,0,0,      0,1,'h200,0,'h340,0,1);
        vec[6]  = mk(0,0,0,0,0,0,0,0,0,0,0,          0,1,'h200,0,'h340,0,1);
        vec[7]  = mk(1,0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        vec[8]  = mk(0,1,'h300,1,'h400,0,0,0,0,0,0,  0,0,0,0,0,0,0);
        vec[9]  = mk(0,0,0,0,0,0,1,'h300,0,0,0,      0,0,'h300,1,'h304,0,0);
        vec[10] = mk(0,1,'h10,0,0,0,0,0,0,0,0,       0,0,'h300,0,'h304,0,0);
        vec[11] = mk(0,1,'h14,0,0,0,0,0,0,0,0,       0,0,'h300,0,'h304,0,0);
        vec[12] = mk(0,1,'h18,0,0,0,0,0,0,0,0,       0,0,'h300,0,'h304,0,0);
        vec[13] = mk(0,1,'h1C,0,0,0,0,0,0,0,0,       0,0,'h300,0,'h304,1,0);
        vec[14] = mk(0,1,'h20,0,0,0,1,'h10,0,1,0,    1,0,'h10,0,'h304,1,0);
        vec[15] = mk(0,0,0,0,0,0,1,'h14,0,1,0,       1,0,'h14,0,'h304,0,0);
        vec[16] = mk(0,0,0,0,0,0,1,'h18,0,1,0,       1,0,'h18,0,'h304,0,0);
        vec[17] = mk(0,0,0,0,0,0,1,'h1C,0,1,0,       1,0,'h1C,0,'h304,0,0);
        vec[18] = mk(0,0,0,0,0,0,1,'h20,0,1,0,       1,0,'h20,0,'h304,0,0);
        vec[19] = mk(0,1,'h40,0,0,0,0,0,0,0,0,       0,0,'h20,0,'h304,0,0);
        vec[20] = mk(0,0,0,0,0,1,1,'h40,0,1,0,       0,0,'h20,0,'h304,0,0);
        vec[21] = mk(0,0,0,0,0,0,1,'h40,0,1,0,       1,0,'h40,0,'h304,0,0);
        vec[22] = mk(0,1,'h50,0,0,0,0,0,0,0,0,       0,0,'h40,0,'h304,0,0);
        vec[23] = mk(1,0,0,0,0,0,1,'h50,0,1,0,       0,0,0,0,0,0,0);
        vec[24] = mk(0,0,0,0,0,0,1,'h50,0,1,0,       0,0,0,0,0,0,1);
        vec[25] = mk(1,0,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);

        set_in(1,0,0,0,0,0,0,0,0,0,0);
        @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            set_in(vec[i].r, vec[i].ifv, vec[i].ifpc, vec[i].ifpt, vec[i].iftgt, vec[i].st,
                   vec[i].exv, vec[i].expc, vec[i].extgt, vec[i].exbr, vec[i].extk);
            tick();
            $display("vec %0d: we=%0b bt=%0b wa=%h fl=%0b rp=%h full=%0b err=%0b", i,
                     WriteEn_o, BranchTaken_o, WriteAddr_o, Flush_o, RedirectPC_o, Full_o, Err_o);
            chk($sformatf("vec%0d WriteEn_o", i), 32'(WriteEn_o), 32'(vec[i].we));
            chk($sformatf("vec%0d BranchTaken_o", i), 32'(BranchTaken_o), 32'(vec[i].bt));
            chk($sformatf("vec%0d WriteAddr_o", i), WriteAddr_o, vec[i].wa);
            chk($sformatf("vec%0d Flush_o", i), 32'(Flush_o), 32'(vec[i].fl));
            chk($sformatf("vec%0d RedirectPC_o", i), RedirectPC_o, vec[i].rp);
            chk($sformatf("vec%0d Full_o", i), 32'(Full_o), 32'(vec[i].fu));
            chk($sformatf("vec%0d Err_o", i), 32'(Err_o), 32'(vec[i].er));
        end

        // Random traffic; EX usually presents the true head so most cycles are real resolutions.
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 99) < 3);
            IF_Valid_i      = 1'($urandom_range(0, 1));
            IF_PC_i         = 32'($urandom_range(0, 255)) << 2;
            IF_PredTaken_i  = 1'($urandom_range(0, 1));
            IF_PredTarget_i = 32'($urandom_range(0, 7)) << 2;
            Stall_i         = ($urandom_range(0, 99) < 15);
            EX_Valid_i      = 1'($urandom_range(0, 1));
            EX_PC_i         = (mq.size() > 0 && $urandom_range(0, 99) < 95) ? mq[0].pc
                                                                           : 32'($urandom);
            EX_IsBranch_i   = ($urandom_range(0, 3) != 0);
            EX_Taken_i      = 1'($urandom_range(0, 1));
            EX_Target_i     = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].tgt
                                                                          : 32'($urandom_range(0, 7)) << 2;
            tick();
            cmp_model();
        end

`ifdef BR_RESOLVE_STATS_EN
        set_in(1,0,0,0,0,0,0,0,0,0,0);         tick();
        set_in(0,1,'h100,0,0,0,0,0,0,0,0);     tick();
        set_in(0,0,0,0,0,0,1,'h100,0,1,0);     tick();
        set_in(0,1,'h104,1,'h200,0,0,0,0,0,0); tick();
        set_in(0,0,0,0,0,0,1,'h104,'h200,1,1); tick();
        set_in(0,1,'h108,0,0,0,0,0,0,0,0);     tick();
        set_in(0,0,0,0,0,0,1,'h108,'h300,1,1); tick();
        set_in(0,0,0,0,0,0,0,0,0,0,0);         tick();
        $display("stats: branches=%0d misses=%0d", BranchCnt_o, MissCnt_o);
        chk("stats BranchCnt_o", BranchCnt_o, 32'd3);
        chk("stats MissCnt_o", MissCnt_o, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
